// File: rtl/store_unit.sv
// Store buffer: DEPTH-entry FIFO of stores that drains to data memory as lane-positioned beats.
// Define STORE_SPLIT_MISALIGNED_EN to split misaligned stores into two beats; otherwise they are flagged and dropped.
module store_unit #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     st_valid,
    output logic                     st_ready,
    input  logic [ADDR_W-1:0]        st_addr,
    input  logic [31:0]              st_data,
    input  logic [1:0]               st_size,
    output logic                     st_misaligned,
    output logic                     mem_req,
    input  logic                     mem_gnt,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [31:0]              mem_wdata,
    output logic [3:0]               mem_be,
    output logic                     st_empty,
    output logic [$clog2(DEPTH):0]   st_count
);

    localparam int PW = $clog2(DEPTH);

    typedef enum logic {
        BEAT0,
        BEAT1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [ADDR_W-1:0] r_addr [DEPTH];
    logic [31:0]       r_data [DEPTH];
    logic [1:0]        r_size [DEPTH];
    logic [PW-1:0]     r_wptr;
    logic [PW-1:0]     r_rptr;
    logic [PW:0]       r_count;

    logic              w_full;
    logic              w_nonempty;
    logic              w_push;
    logic              w_beat;
    logic              w_pop;
    logic              w_split;

    logic [ADDR_W-1:0] w_h_addr;
    logic [31:0]       w_h_data;
    logic [1:0]        w_h_size;
    logic [1:0]        w_k;
    logic [3:0]        w_base;
    logic [63:0]       w_dshift;
    logic [7:0]        w_mask;
    logic [ADDR_W-1:0] w_word_addr;

    assign w_full     = (r_count == (PW+1)'(DEPTH));
    assign w_nonempty = (r_count != '0);
    assign st_ready   = !w_full;
    assign st_empty   = !w_nonempty;
    assign st_count   = r_count;
    assign mem_req    = w_nonempty;

`ifdef STORE_SPLIT_MISALIGNED_EN
    assign st_misaligned = 1'b0;
    assign w_push        = st_valid && st_ready;
`else
    logic w_st_mis;

    always_comb begin
        w_st_mis = 1'b0;
        case (st_size)
            2'b01:   w_st_mis = 1'b0;
            2'b10:   w_st_mis = st_addr[0];
            default: w_st_mis = (st_addr[1:0] != 2'b00);
        endcase
    end

    // Misaligned requests are still consumed (handshake completes) but never enter the FIFO.
    assign st_misaligned = st_valid && w_st_mis;
    assign w_push        = st_valid && st_ready && !w_st_mis;
`endif

    // Head-entry lane placement: 64-bit shifted data and 8-bit mask span both beats.
    assign w_h_addr    = r_addr[r_rptr];
    assign w_h_data    = r_data[r_rptr];
    assign w_h_size    = r_size[r_rptr];
    assign w_k         = w_h_addr[1:0];
    assign w_word_addr = {w_h_addr[ADDR_W-1:2], 2'b00};

    always_comb begin
        w_base = 4'b1111;
        case (w_h_size)
            2'b01:   w_base = 4'b0001;
            2'b10:   w_base = 4'b0011;
            default: w_base = 4'b1111;
        endcase
    end

    assign w_dshift = {32'h0, w_h_data} << {w_k, 3'b000};
    assign w_mask   = {4'h0, w_base} << w_k;
    assign w_split  = |w_mask[7:4];

    assign w_beat = w_nonempty && mem_gnt;
    assign w_pop  = w_beat && ((r_state == BEAT1) || !w_split);

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        if (w_nonempty) begin
            if (r_state == BEAT1) begin
                mem_addr  = w_word_addr + ADDR_W'(4);
                mem_wdata = w_dshift[63:32];
                mem_be    = w_mask[7:4];
            end else begin
                mem_addr  = w_word_addr;
                mem_wdata = w_dshift[31:0];
                mem_be    = w_mask[3:0];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_beat) begin
            case (r_state)
                BEAT0: begin
`ifdef STORE_SPLIT_MISALIGNED_EN
                    if (w_split) w_state_nxt = BEAT1;
`endif
                end
                BEAT1:   w_state_nxt = BEAT0;
                default: w_state_nxt = BEAT0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= BEAT0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the count alone decides which slots are live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_wptr] <= st_addr;
            r_data[r_wptr] <= st_data;
            r_size[r_wptr] <= st_size;
        end
    end

endmodule

// File: tb/tb_store_unit.sv
// Randomised and directed bench for store_unit against a beat-queue reference model.
module tb_store_unit;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 32;
    localparam int CW     = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              st_valid;
    logic              st_ready;
    logic [ADDR_W-1:0] st_addr;
    logic [31:0]       st_data;
    logic [1:0]        st_size;
    logic              st_misaligned;
    logic              mem_req;
    logic              mem_gnt;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_be;
    logic              st_empty;
    logic [CW-1:0]     st_count;

    store_unit #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .st_valid      (st_valid),
        .st_ready      (st_ready),
        .st_addr       (st_addr),
        .st_data       (st_data),
        .st_size       (st_size),
        .st_misaligned (st_misaligned),
        .mem_req       (mem_req),
        .mem_gnt       (mem_gnt),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_be        (mem_be),
        .st_empty      (st_empty),
        .st_count      (st_count)
    );

    always #5 clk = ~clk;

`ifdef STORE_SPLIT_MISALIGNED_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        bit          last;
    } beat_t;

    beat_t q[$];
    int    mcount = 0;
    int    vec    = 0;
    int    errs   = 0;

    function automatic bit is_mis(logic [31:0] a, logic [1:0] s);
        if (s == 2'b01) return 1'b0;
        if (s == 2'b10) return a[0];
        return a[1:0] != 2'b00;
    endfunction

    // Expected memory beats for one accepted store, straight from the lane rule.
    function automatic void add_store(logic [31:0] a, logic [31:0] d, logic [1:0] s);
        int              k;
        int              nb;
        int              m;
        longint unsigned dd;
        beat_t           b;
        k  = int'(a[1:0]);
        nb = (s == 2'b01) ? 1 : (s == 2'b10) ? 2 : 4;
        m  = ((1 << nb) - 1) << k;
        dd = longint'(d) << (8 * k);
        b.addr  = {a[31:2], 2'b00};
        b.wdata = dd[31:0];
        b.be    = 4'(m);
        b.last  = (m >> 4) == 0;
        q.push_back(b);
        if (!b.last) begin
            b.addr  = b.addr + 32'd4;
            b.wdata = dd[63:32];
            b.be    = 4'(m >> 4);
            b.last  = 1'b1;
            q.push_back(b);
        end
    endfunction

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] s, input logic g);
        st_valid = v;
        st_addr  = a;
        st_data  = d;
        st_size  = s;
        mem_gnt  = g;
        #1;
    endtask

    // Advances the model with the inputs presented this cycle, then crosses one clock edge.
    task automatic tick();
        bit pushed;
        if (!rst_n) begin
            q.delete();
            mcount = 0;
        end else begin
            pushed = st_valid && (mcount < DEPTH) && (SPLIT || !is_mis(st_addr, st_size));
            if (mem_gnt && q.size() > 0) begin
                if (q[0].last) mcount--;
                void'(q.pop_front());
            end
            if (pushed) begin
                add_store(st_addr, st_data, st_size);
                mcount++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        vec++; if (st_count !== '0) begin errs++; $display("FAIL reset_count got=%0d want=0", st_count); end
        vec++; if (st_empty !== 1'b1) begin errs++; $display("FAIL reset_empty got=%b want=1", st_empty); end
        vec++; if (mem_req !== 1'b0) begin errs++; $display("FAIL reset_req got=%b want=0", mem_req); end
        vec++; if (mem_be !== 4'b0) begin errs++; $display("FAIL reset_be got=%b want=0000", mem_be); end
        vec++; if (mem_wdata !== 32'h0) begin errs++; $display("FAIL reset_wdata got=%h want=0", mem_wdata); end
        vec++; if (mem_addr !== 32'h0) begin errs++; $display("FAIL reset_addr got=%h want=0", mem_addr); end
        vec++; if (st_ready !== 1'b1) begin errs++; $display("FAIL reset_ready got=%b want=1", st_ready); end
    endtask

    task automatic test_byte();
        drive(1'b1, 32'h1002, 32'h0000_00AB, 2'b01, 1'b0);
        vec++; if (st_misaligned !== 1'b0) begin errs++; $display("FAIL sb_mis got=%b want=0", st_misaligned); end
        tick();
        drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
        vec++; if (mem_req !== 1'b1) begin errs++; $display("FAIL sb_req got=%b want=1", mem_req); end
        vec++; if (mem_addr !== 32'h1000) begin errs++; $display("FAIL sb_addr got=%h want=00001000", mem_addr); end
        vec++; if (mem_be !== 4'b0100) begin errs++; $display("FAIL sb_be got=%b want=0100", mem_be); end
        vec++; if (mem_wdata[23:16] !== 8'hAB) begin errs++; $display("FAIL sb_lane got=%h want=ab", mem_wdata[23:16]); end
        vec++; if (st_count !== CW'(1)) begin errs++; $display("FAIL sb_count got=%0d want=1", st_count); end
        drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b1);
        tick();
        vec++; if (st_empty !== 1'b1) begin errs++; $display("FAIL sb_empty got=%b want=1", st_empty); end
        vec++; if (mem_req !== 1'b0) begin errs++; $display("FAIL sb_done_req got=%b want=0", mem_req); end
    endtask

    task automatic test_half();
        drive(1'b1, 32'h2001, 32'h0000_1234, 2'b10, 1'b0);
        vec++; if (st_misaligned !== !SPLIT) begin errs++; $display("FAIL sh_mis got=%b want=%b", st_misaligned, !SPLIT); end
        vec++; if (st_ready !== 1'b1) begin errs++; $display("FAIL sh_ready got=%b want=1", st_ready); end
        tick();
        drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
`ifdef STORE_SPLIT_MISALIGNED_EN
        vec++; if (mem_addr !== 32'h2000) begin errs++; $display("FAIL sh_addr got=%h want=00002000", mem_addr); end
        vec++; if (mem_be !== 4'b0110) begin errs++; $display("FAIL sh_be got=%b want=0110", mem_be); end
        vec++; if (mem_wdata[23:8] !== 16'h1234) begin errs++; $display("FAIL sh_lane got=%h want=1234", mem_wdata[23:8]); end
        drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b1);
        tick();
        vec++; if (st_empty !== 1'b1) begin errs++; $display("FAIL sh_onebeat got=%b want=1", st_empty); end
`else
        vec++; if (st_empty !== 1'b1) begin errs++; $display("FAIL sh_nopush_empty got=%b want=1", st_empty); end
        vec++; if (st_count !== '0) begin errs++; $display("FAIL sh_nopush_count got=%0d want=0", st_count); end
        vec++; if (mem_req !== 1'b0) begin errs++; $display("FAIL sh_nopush_req got=%b want=0", mem_req); end
`endif
        drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    endtask

    task automatic test_split();
        drive(1'b1, 32'h3003, 32'hDDCC_BBAA, 2'b00, 1'b0);
`ifdef STORE_SPLIT_MISALIGNED_EN
        tick();
        drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
        vec++; if (mem_addr !== 32'h3000) begin errs++; $display("FAIL sw_b0_addr got=%h want=00003000", mem_addr); end
        vec++; if (mem_be !== 4'b1000) begin errs++; $display("FAIL sw_b0_be got=%b want=1000", mem_be); end
        vec++; if (mem_wdata[31:24] !== 8'hAA) begin errs++; $display("FAIL sw_b0_lane got=%h want=aa", mem_wdata[31:24]); end
        drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b1);
        tick();
        vec++; if (mem_addr !== 32'h3004) begin errs++; $display("FAIL sw_b1_addr got=%h want=00003004", mem_addr); end
        vec++; if (mem_be !== 4'b0111) begin errs++; $display("FAIL sw_b1_be got=%b want=0111", mem_be); end
        vec++; if (mem_wdata[23:0] !== 24'hDDCCBB) begin errs++; $display("FAIL sw_b1_lane got=%h want=ddccbb", mem_wdata[23:0]); end
        vec++; if (st_count !== CW'(1)) begin errs++; $display("FAIL sw_nopop got=%0d want=1", st_count); end
        tick();
        vec++; if (st_empty !== 1'b1) begin errs++; $display("FAIL sw_popped got=%b want=1", st_empty); end
`else
        vec++; if (st_misaligned !== 1'b1) begin errs++; $display("FAIL sw_mis got=%b want=1", st_misaligned); end
        tick();
        drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
        vec++; if (st_empty !== 1'b1) begin errs++; $display("FAIL sw_nopush got=%b want=1", st_empty); end
`endif
        drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    endtask

    task automatic test_full();
        logic [31:0] ea [DEPTH];
        logic [31:0] ed [DEPTH];
        for (int i = 0; i < DEPTH; i++) begin
            ea[i] = 32'h0000_5000 + (32'(i) << 4) + ($urandom & 32'h0000_0F00);
            ed[i] = $urandom;
            drive(1'b1, ea[i], ed[i], 2'b00, 1'b0);
            vec++; if (st_ready !== 1'b1) begin errs++; $display("FAIL full_fill_ready[%0d] got=%b want=1", i, st_ready); end
            tick();
        end
        drive(1'b1, 32'h0000_6660, 32'h1111_2222, 2'b00, 1'b0);
        vec++; if (st_ready !== 1'b0) begin errs++; $display("FAIL full_ready got=%b want=0", st_ready); end
        vec++; if (st_count !== CW'(DEPTH)) begin errs++; $display("FAIL full_count got=%0d want=%0d", st_count, DEPTH); end
        tick();
        for (int s = 0; s < 3; s++) begin
            drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
            vec++; if (mem_addr !== ea[0] || mem_wdata !== ed[0] || mem_be !== 4'hF) begin
                errs++; $display("FAIL full_stall[%0d] got=%h/%h/%b want=%h/%h/1111", s, mem_addr, mem_wdata, mem_be, ea[0], ed[0]);
            end
            tick();
        end
        for (int i = 0; i < DEPTH; i++) begin
            // First drain cycle also offers a store: pop and push together while full must not push.
            drive(i == 0, 32'h0000_7770, 32'h3333_4444, 2'b00, 1'b1);
            vec++; if (mem_addr !== ea[i] || mem_wdata !== ed[i] || mem_be !== 4'hF) begin
                errs++; $display("FAIL full_drain[%0d] got=%h/%h/%b want=%h/%h/1111", i, mem_addr, mem_wdata, mem_be, ea[i], ed[i]);
            end
            tick();
            if (i == 0) begin
                vec++; if (st_count !== CW'(DEPTH - 1)) begin errs++; $display("FAIL full_nopushthru got=%0d want=%0d", st_count, DEPTH - 1); end
            end
        end
        vec++; if (st_empty !== 1'b1) begin errs++; $display("FAIL full_drained got=%b want=1", st_empty); end
        drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] pa;
        logic [31:0] pd;
        logic [31:0] a;
        logic [31:0] d;
        pa = '0;
        pd = '0;
        for (int i = 0; i < 3 * DEPTH; i++) begin
            a = 32'h0000_8000 + 32'(4 * i);
            d = $urandom;
            drive(1'b1, a, d, 2'b00, 1'b1);
            vec++; if (st_ready !== 1'b1) begin errs++; $display("FAIL b2b_ready[%0d] got=%b want=1", i, st_ready); end
            if (i > 0) begin
                vec++; if (st_count !== CW'(1)) begin errs++; $display("FAIL b2b_count[%0d] got=%0d want=1", i, st_count); end
                vec++; if (mem_addr !== pa || mem_wdata !== pd) begin
                    errs++; $display("FAIL b2b_data[%0d] got=%h/%h want=%h/%h", i, mem_addr, mem_wdata, pa, pd);
                end
            end
            pa = a;
            pd = d;
            tick();
        end
        drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b1);
        vec++; if (mem_addr !== pa || mem_wdata !== pd) begin errs++; $display("FAIL b2b_last got=%h/%h want=%h/%h", mem_addr, mem_wdata, pa, pd); end
        tick();
        vec++; if (st_empty !== 1'b1) begin errs++; $display("FAIL b2b_empty got=%b want=1", st_empty); end
        drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    endtask

    task automatic test_reset_split();
`ifdef STORE_SPLIT_MISALIGNED_EN
        drive(1'b1, 32'h4001, 32'hCAFE_BABE, 2'b00, 1'b0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b1);
        tick();
        vec++; if (mem_addr !== 32'h4004) begin errs++; $display("FAIL rs_in_beat1 got=%h want=00004004", mem_addr); end
`else
        drive(1'b1, 32'h4000, 32'hCAFE_BABE, 2'b00, 1'b0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
        vec++; if (mem_req !== 1'b1) begin errs++; $display("FAIL rs_pending got=%b want=1", mem_req); end
`endif
        rst_n = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
        tick();
        rst_n = 1'b1;
        #1;
        vec++; if (mem_req !== 1'b0) begin errs++; $display("FAIL rs_req got=%b want=0", mem_req); end
        vec++; if (st_count !== '0) begin errs++; $display("FAIL rs_count got=%0d want=0", st_count); end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b1);
            vec++; if (mem_req !== 1'b0) begin errs++; $display("FAIL rs_no_beat1[%0d] got=%b/%h want=0", i, mem_req, mem_addr); end
            tick();
        end
        drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    endtask

    task automatic test_random();
        logic        v;
        logic [31:0] a;
        logic [1:0]  s;
        logic        exp_mis;
        int          guard;
        for (int i = 0; i < 500; i++) begin
            v = ($urandom % 3) != 0;
            a = $urandom & 32'h0000_FFFF;
            s = 2'($urandom);
            drive(v, a, $urandom, s, ($urandom % 4) != 0);
`ifdef STORE_SPLIT_MISALIGNED_EN
            exp_mis = 1'b0;
`else
            exp_mis = v && is_mis(a, s);
`endif
            vec++; if (st_ready !== (mcount < DEPTH)) begin errs++; $display("FAIL rnd_ready[%0d] got=%b want=%b", i, st_ready, mcount < DEPTH); end
            vec++; if (st_count !== CW'(mcount)) begin errs++; $display("FAIL rnd_count[%0d] got=%0d want=%0d", i, st_count, mcount); end
            vec++; if (st_misaligned !== exp_mis) begin errs++; $display("FAIL rnd_mis[%0d] got=%b want=%b", i, st_misaligned, exp_mis); end
            vec++; if (mem_req !== (q.size() != 0)) begin errs++; $display("FAIL rnd_req[%0d] got=%b want=%b", i, mem_req, q.size() != 0); end
            if (q.size() != 0) begin
                vec++; if (mem_addr !== q[0].addr || mem_wdata !== q[0].wdata || mem_be !== q[0].be) begin
                    errs++; $display("FAIL rnd_beat[%0d] got=%h/%h/%b want=%h/%h/%b", i, mem_addr, mem_wdata, mem_be, q[0].addr, q[0].wdata, q[0].be);
                end
            end
            tick();
        end
        guard = 0;
        while (q.size() != 0 && guard < 4 * DEPTH + 4) begin
            drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b1);
            vec++; if (mem_addr !== q[0].addr || mem_wdata !== q[0].wdata || mem_be !== q[0].be) begin
                errs++; $display("FAIL rnd_drain got=%h/%h/%b want=%h/%h/%b", mem_addr, mem_wdata, mem_be, q[0].addr, q[0].wdata, q[0].be);
            end
            tick();
            guard++;
        end
        vec++; if (st_empty !== 1'b1) begin errs++; $display("FAIL rnd_final_empty got=%b want=1 (drain budget %0d)", st_empty, guard); end
        drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired after %0d vectors", vec);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n    = 1'b0;
        st_valid = 1'b0;
        st_addr  = '0;
        st_data  = '0;
        st_size  = '0;
        mem_gnt  = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_byte();
        test_half();
        test_split();
        test_full();
        test_back_to_back();
        test_reset_split();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
